pattern_tx: RTL and testbench

Serial pattern transmitter that produces the single-bit stream `x` consumed by the team's serial sequence-detector machines. A parallel word is loaded on a start request and shifted out MSB-first, one bit per clock, optionally followed by an even-parity bit. A `done` pulse marks the end of each word. It sits upstream of a detector and drives its `x` input directly, so a bench or a top level can replay exact bit patterns against a detector FSM.

---
 rtl/pattern_tx_pkg.sv | 12 +
 rtl/pattern_tx_bit_counter.sv | 26 ++
 rtl/pattern_tx.sv | 99 +++++++++
 tb/tb_pattern_tx.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: state codes and
// the width of the observable state output.
package pattern_tx_pkg;

    localparam int S_W = 3;

    localparam logic [S_W-1:0] ST_IDLE   = 3'b000;
    localparam logic [S_W-1:0] ST_SHIFT  = 3'b001;
    localparam logic [S_W-1:0] ST_PARITY = 3'b010;
    localparam logic [S_W-1:0] ST_DONE   = 3'b100;

endpackage

// File: rtl/pattern_tx_bit_counter.sv
// Loadable down-counter that saturates at zero; the transmitter reloads it
// on every accepted word.
module bit_counter #(
    parameter int WIDTH = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && !zero)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a captured word out MSB-first on x,
// optionally followed by an even-parity bit, then pulses done.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [S_W-1:0]   S
);

    localparam int CW = $clog2(WIDTH);

    logic [S_W-1:0]   state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic             par;
    logic             accept;
    logic [CW-1:0]    count;
    logic             cnt_zero;

    assign accept = (state == ST_IDLE) && start;

    bit_counter #(.WIDTH(CW)) u_bit_counter (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (accept),
        .load_val (CW'(WIDTH - 1)),
        .dec      (state == ST_SHIFT),
        .count    (count),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_SHIFT;
            ST_SHIFT:  if (cnt_zero) state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_DONE;
            ST_PARITY: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // The word and its parity are captured only at acceptance, so data may
    // wander freely while the block is busy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            shreg <= '0;
            par   <= 1'b0;
        end else if (accept) begin
            shreg <= data;
            par   <= ^data;
        end else if (state == ST_SHIFT) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        x       = 1'b0;
        x_valid = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            ST_SHIFT: begin
                x       = shreg[WIDTH-1];
                x_valid = 1'b1;
                busy    = 1'b1;
            end
            ST_PARITY: begin
                x       = par;
                x_valid = 1'b1;
                busy    = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign S = state;

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: an 8-bit parity instance and a 3-bit no-parity
// instance checked cycle by cycle against a per-cycle output model.
module tb_pattern_tx;
    import pattern_tx_pkg::*;

    logic           CLK;
    logic           RESET;
    logic           start_a, start_b;
    logic [7:0]     data_a;
    logic [2:0]     data_b;
    logic           x_a, xv_a, busy_a, done_a;
    logic           x_b, xv_b, busy_b, done_b;
    logic [S_W-1:0] S_a, S_b;

    int tests = 0;
    int fails = 0;
    int busy_cnt;
    int done_cnt;
    int xb_edges = 0;

    pattern_tx #(.WIDTH(8), .PARITY_EN(1)) u_a (
        .CLK(CLK), .RESET(RESET), .start(start_a), .data(data_a),
        .x(x_a), .x_valid(xv_a), .busy(busy_a), .done(done_a), .S(S_a)
    );

    pattern_tx #(.WIDTH(3), .PARITY_EN(0)) u_b (
        .CLK(CLK), .RESET(RESET), .start(start_b), .data(data_b),
        .x(x_b), .x_valid(xv_b), .busy(busy_b), .done(done_b), .S(S_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Every transition on the detector-facing line of the 3-bit instance.
    always @(x_b) xb_edges = xb_edges + 1;

    // Expected {S, x, x_valid, busy, done} in cycle c after acceptance edge 0.
    function automatic logic [6:0] model(int c, logic [15:0] d, int w, bit pe);
        logic [15:0] dm;
        dm = d & ((16'd1 << w) - 16'd1);
        if (c >= 1 && c <= w)           return {3'b001, dm[w-c], 1'b1, 1'b1, 1'b0};
        if (pe && c == w + 1)           return {3'b010, ^dm, 1'b1, 1'b1, 1'b0};
        if (c == w + 1 + int'(pe))      return {3'b100, 1'b0, 1'b0, 1'b1, 1'b1};
        return 7'b0;
    endfunction

    function automatic logic [6:0] obs(bit sel);
        if (sel) return {S_b, x_b, xv_b, busy_b, done_b};
        return {S_a, x_a, xv_a, busy_a, done_a};
    endfunction

    task automatic chk(string tag, logic [15:0] o, logic [15:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One-cycle start, then check every cycle up to and including the
    // IDLE cycle that follows done. data is scrambled while busy.
    task automatic send(bit sel, logic [15:0] d, string tag);
        int w;
        bit pe;
        w  = sel ? 3 : 8;
        pe = sel ? 1'b0 : 1'b1;
        if (sel) begin start_b = 1'b1; data_b = d[2:0]; end
        else     begin start_a = 1'b1; data_a = d[7:0]; end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 1; c <= w + 2 + int'(pe); c++) begin
            if (sel) data_b = 3'($urandom);
            else     data_a = 8'($urandom);
            chk($sformatf("%s_c%0d", tag, c), 16'(obs(sel)), 16'(model(c, d, w, pe)));
            if (obs(sel) & 7'b0000010) busy_cnt++;
            if (obs(sel) & 7'b0000001) done_cnt++;
            if (c < w + 2 + int'(pe)) tick();
        end
        chk({tag, "_done_cnt"}, 16'(done_cnt), 16'd1);
    endtask

    initial begin
        logic [15:0] d;
        int e0;
        RESET   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        data_a  = '0;
        data_b  = '0;
        #1;
        chk("reset_a", 16'(obs(0)), 16'd0);
        chk("reset_b", 16'(obs(1)), 16'd0);
        #20;
        chk("reset_a_clocked", 16'(obs(0)), 16'd0);
        RESET = 1'b0;
        tick();

        send(0, 16'h00A5, "a5");
        send(0, 16'h0007, "h07");
        chk("h07_busy_cycles", 16'(busy_cnt), 16'd10);

        // start held high: words back-to-back every 11 cycles, data = FF only
        // at the acceptance edges
        start_a = 1'b1;
        data_a  = 8'hFF;
        tick();
        done_cnt = 0;
        for (int c = 1; c <= 33; c++) begin
            int ph;
            ph = ((c - 1) % 11) + 1;
            chk($sformatf("held_c%0d", c), 16'(obs(0)), 16'(model(ph, 16'h00FF, 8, 1'b1)));
            if (done_a) done_cnt++;
            data_a = (ph == 11) ? 8'hFF : 8'($urandom);
            if (c == 33) start_a = 1'b0;
            tick();
        end
        chk("held_done_cnt", 16'(done_cnt), 16'd3);
        chk("held_idle", 16'(obs(0)), 16'd0);

        // async reset in cycle 4 of a word
        d = 16'($urandom) & 16'h00FF;
        start_a = 1'b1;
        data_a  = d[7:0];
        tick();
        start_a = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_pre_c4", 16'(obs(0)), 16'(model(4, d, 8, 1'b1)));
        #2 RESET = 1'b1;
        #1;
        chk("rst_async", 16'(obs(0)), 16'd0);
        tick();
        chk("rst_held", 16'(obs(0)), 16'd0);
        RESET = 1'b0;
        send(0, 16'h0000 | 16'($urandom_range(0, 255)), "post_rst");

        // 3-bit, no parity: three 1s on the detector line with exactly one
        // rise and one fall
        e0 = xb_edges;
        send(1, 16'h0007, "b111");
        chk("b111_edges", 16'(xb_edges - e0), 16'd2);
        chk("b111_busy", 16'(busy_cnt), 16'd4);

        for (int i = 0; i < 12; i++) begin
            send(0, 16'($urandom) & 16'h00FF, $sformatf("rnd_a%0d", i));
            send(1, 16'($urandom) & 16'h0007, $sformatf("rnd_b%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
